// File: rtl/mem_port_arbiter_pkg.sv
// Shared state encoding and default sizing for the CPU / I/O memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned ADDR_W_DEF       = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned CNT_W_DEF        = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GNT_CPU = 3'd1,
    GNT_IO  = 3'd2,
    RSP_CPU = 3'd3,
    RSP_IO  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating up-counter tracking CPU grants taken while the I/O port waits.
module starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clock,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CNT_W-1:0] cnt;

  assign sat = (cnt == CNT_W'(LIMIT));

  always_ff @(posedge clock) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-port memory between the CPU and the I/O port.
// CPU has priority; the starvation counter forces an I/O grant after STARVE_LIMIT CPU wins.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [DATA_W-1:0] io_wdata,
  output logic [DATA_W-1:0] io_rdata,
  output logic              io_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  logic   write_q;
  logic   cpu_ack_q;
  logic   io_ack_q;
  logic   rsp_read;
  logic   starve_sat;
  logic   io_first;
  logic   starve_inc;
  logic   starve_clr;

  // I/O wins when the CPU is absent or has used up its consecutive-grant allowance
  assign io_first   = io_req && (starve_sat || !cpu_req);
  assign starve_inc = (state == IDLE) && !io_first && cpu_req && io_req;
  assign starve_clr = (state == IDLE) && (io_first || !io_req);

  starve_counter #(
    .CNT_W (CNT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock (clock),
    .rst   (rst),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat)
  );

  // Memory-side controls are loaded on entry to GNT so the synchronous memory sees them in GNT.
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      write_q   <= 1'b0;
      cpu_ack_q <= 1'b0;
      io_ack_q  <= 1'b0;
      rsp_read  <= 1'b0;
    end else begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      write_q   <= 1'b0;
      cpu_ack_q <= 1'b0;
      io_ack_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (io_first) begin
            state     <= GNT_IO;
            mem_addr  <= io_addr;
            mem_wdata <= io_wdata;
            write_q   <= io_we;
            rsp_read  <= !io_we;
          end else if (cpu_req) begin
            state     <= GNT_CPU;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            write_q   <= cpu_we;
            rsp_read  <= !cpu_we;
          end
        end
        GNT_CPU: begin
          state     <= RSP_CPU;
          cpu_ack_q <= 1'b1;
        end
        GNT_IO: begin
          state    <= RSP_IO;
          io_ack_q <= 1'b1;
        end
        RSP_CPU, RSP_IO: state <= IDLE;
        default:         state <= IDLE;
      endcase
    end
  end

  // Reset abandons an in-flight access immediately: no write strobe, no ack in the reset cycle.
  assign mem_write = write_q && !rst;
  assign cpu_ack   = cpu_ack_q && !rst;
  assign io_ack    = io_ack_q && !rst;
  assign cpu_rdata = (cpu_ack && rsp_read) ? mem_rdata : '0;
  assign io_rdata  = (io_ack && rsp_read) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int          LIMIT  = 4;
  localparam int          MAXC   = 2048;

  logic              clock     = 1'b0;
  logic              rst       = 1'b1;
  logic              cpu_req   = 1'b0;
  logic              cpu_we    = 1'b0;
  logic [ADDR_W-1:0] cpu_addr  = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              io_req    = 1'b0;
  logic              io_we     = 1'b0;
  logic [ADDR_W-1:0] io_addr   = '0;
  logic [DATA_W-1:0] io_wdata  = '0;
  logic [DATA_W-1:0] io_rdata;
  logic              io_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata = '0;

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .STARVE_LIMIT (LIMIT),
    .CNT_W        (3)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_write (mem_write),
    .mem_rdata (mem_rdata)
  );

  // Synchronous single-port memory, read-first
  logic [15:0] mem [65536];
  always @(posedge clock) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model: per-cycle expectations scheduled when an access is granted
  bit [15:0] shadow   [65536];
  bit        e_cack   [MAXC];
  bit        e_iack   [MAXC];
  bit        e_wr     [MAXC];
  bit        e_rd     [MAXC];
  bit [15:0] e_maddr  [MAXC];
  bit [15:0] e_mwdata [MAXC];
  bit [15:0] e_raddr  [MAXC];

  int cyc = 0;
  int free_at = 0;
  int starve = 0;
  int checks = 0;
  int errors = 0;
  int cpu_ack_cnt = 0;
  int io_ack_cnt = 0;
  int mw_cnt = 0;
  logic [15:0] last_cpu_rdata = '0;
  byte ack_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit cr, input bit cw, input bit [15:0] ca, input bit [15:0] cd,
                      input bit ir, input bit iw, input bit [15:0] ia, input bit [15:0] id);
    bit [15:0] exp_cd;
    bit [15:0] exp_id;
    bit        io_win;
    bit        cpu_win;
    bit        we;
    bit [15:0] a;
    bit [15:0] d;
    if (cyc + 3 >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1);
    end
    @(negedge clock);
    rst = r;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    io_req = ir;  io_we = iw;  io_addr = ia;  io_wdata = id;
    #1;
    // reset abandons everything scheduled from this cycle on
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        e_cack[cyc+k] = 1'b0; e_iack[cyc+k] = 1'b0;
        e_wr[cyc+k] = 1'b0;   e_rd[cyc+k] = 1'b0;
        if (k > 0) begin e_maddr[cyc+k] = '0; e_mwdata[cyc+k] = '0; end
      end
      free_at = cyc + 1;
      starve = 0;
    end
    if (e_wr[cyc]) shadow[e_maddr[cyc]] = e_mwdata[cyc];
    exp_cd = (e_cack[cyc] && e_rd[cyc]) ? shadow[e_raddr[cyc]] : 16'h0;
    exp_id = (e_iack[cyc] && e_rd[cyc]) ? shadow[e_raddr[cyc]] : 16'h0;

    check("cpu_ack",   32'(cpu_ack),   32'(e_cack[cyc]));
    check("io_ack",    32'(io_ack),    32'(e_iack[cyc]));
    check("cpu_rdata", 32'(cpu_rdata), 32'(exp_cd));
    check("io_rdata",  32'(io_rdata),  32'(exp_id));
    check("mem_write", 32'(mem_write), 32'(e_wr[cyc]));
    check("mem_addr",  32'(mem_addr),  32'(e_maddr[cyc]));
    check("mem_wdata", 32'(mem_wdata), 32'(e_mwdata[cyc]));

    if (cpu_ack === 1'b1) begin
      ack_log.push_back(8'h43);
      cpu_ack_cnt++;
      last_cpu_rdata = cpu_rdata;
    end
    if (io_ack === 1'b1) begin
      ack_log.push_back(8'h49);
      io_ack_cnt++;
    end
    if (mem_write === 1'b1) mw_cnt++;

    // arbitration decision for an idle port
    if (!r && cyc >= free_at) begin
      io_win  = ir && (starve == LIMIT || !cr);
      cpu_win = !io_win && cr;
      if (io_win || cpu_win) begin
        we = io_win ? iw : cw;
        a  = io_win ? ia : ca;
        d  = io_win ? id : cd;
        e_maddr[cyc+1]  = a;
        e_mwdata[cyc+1] = d;
        e_wr[cyc+1]     = we;
        if (io_win) e_iack[cyc+2] = 1'b1;
        else        e_cack[cyc+2] = 1'b1;
        e_rd[cyc+2]    = !we;
        e_raddr[cyc+2] = a;
        free_at = cyc + 3;
      end
      if (io_win || !ir) starve = 0;
      else if (cpu_win && starve < LIMIT) starve++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic cpu_xfer(input bit we, input bit [15:0] a, input bit [15:0] d);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, we, a, d, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(1);
  endtask

  int n0;
  int i0;
  int m0;

  initial begin
    for (int k = 0; k < 65536; k++) begin
      mem[k] = '0;
      shadow[k] = '0;
    end
    mem[16'h0010] = 16'hBEEF;
    shadow[16'h0010] = 16'hBEEF;

    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(2);

    cpu_xfer(1'b0, 16'h0010, 16'h0);
    check("read_beef", 32'(last_cpu_rdata), 32'h0000_BEEF);

    cpu_xfer(1'b1, 16'h0020, 16'h1234);
    cpu_xfer(1'b0, 16'h0020, 16'h0);
    check("read_after_write", 32'(last_cpu_rdata), 32'h0000_1234);

    // reset while a CPU write is in its grant cycle
    n0 = cpu_ack_cnt; m0 = mw_cnt;
    step(1'b0, 1'b1, 1'b1, 16'h0030, 16'hDEAD, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b1, 1'b1, 16'h0030, 16'hDEAD, 1'b0, 1'b0, 16'h0, 16'h0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(3);
    check("rst_no_ack",   32'(cpu_ack_cnt - n0), 32'd0);
    check("rst_no_write", 32'(mw_cnt - m0),      32'd0);
    check("rst_mem_kept", 32'(mem[16'h0030]),    32'd0);

    // I/O write with the CPU silent
    n0 = cpu_ack_cnt; i0 = io_ack_cnt; m0 = mw_cnt;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h8000, 16'h00FF);
    idle(2);
    check("io_ack_once",    32'(io_ack_cnt - i0),  32'd1);
    check("io_write_once",  32'(mw_cnt - m0),      32'd1);
    check("io_no_cpu_ack",  32'(cpu_ack_cnt - n0), 32'd0);
    check("io_mem_written", 32'(mem[16'h8000]),    32'h0000_00FF);

    // request dropped after one cycle still completes exactly once
    n0 = cpu_ack_cnt;
    step(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    idle(6);
    check("dropped_req_acks", 32'(cpu_ack_cnt - n0), 32'd1);

    // continuous contention: four CPU grants then one forced I/O grant
    ack_log.delete();
    for (int k = 0; k < 30; k++) step(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, 1'b0, 16'h0050, 16'h0);
    idle(3);
    check("contention_grants", 32'(ack_log.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("grant_order%0d", k), 32'(ack_log[k]), (k % 5 == 4) ? 32'h49 : 32'h43);
    end

    // random traffic with occasional reset
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 99) < 60), 1'($urandom_range(0, 1)),
           16'h0010 + 16'($urandom_range(0, 7)), 16'($urandom),
           ($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)),
           16'h0010 + 16'($urandom_range(0, 7)), 16'($urandom));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
